// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX byte channel between NUM_SRC producers.
// Grants are per message (round-robin, held until the last byte); a watchdog reclaims stalled grants.
module uart_tx_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SRC_W   = 2,
  parameter int unsigned TIMEOUT = 60000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC*8-1:0]   src_data,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [NUM_SRC-1:0]     src_last,
  output logic [NUM_SRC-1:0]     src_ready,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_tx_valid,
  input  logic                   uart_tx_ready,
  output logic [SRC_W-1:0]       grant_id,
  output logic                   busy,
  output logic [7:0]             timeout_count
);

  localparam int unsigned WD_W  = 16;
  localparam int unsigned CNT_W = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       r_state,   w_state_nxt;
  logic [SRC_W-1:0] r_ptr,     w_ptr_nxt;
  logic [SRC_W-1:0] r_grant,   w_grant_nxt;
  logic             r_busy,    w_busy_nxt;
  logic [7:0]       r_tx_data, w_tx_data_nxt;
  logic             r_tx_valid, w_tx_valid_nxt;
  logic [WD_W-1:0]  r_wd,      w_wd_nxt;
  logic [CNT_W-1:0] r_tmo,     w_tmo_nxt;

  logic [7:0]       w_bytes [NUM_SRC];
  logic [7:0]       w_sel_data;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic             w_out_free;
  logic             w_accept;
  logic             w_found;
  logic [SRC_W-1:0] w_win;
  int unsigned      w_cand;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_bytes
    assign w_bytes[k] = src_data[k*8 +: 8];
  end

  assign w_sel_data  = w_bytes[r_grant];
  assign w_sel_valid = src_valid[r_grant];
  assign w_sel_last  = src_last[r_grant];
  assign w_out_free  = !r_tx_valid || uart_tx_ready;
  assign w_accept    = (r_state == ST_GRANT) && w_sel_valid && w_out_free;

  // Round-robin search starting just above the last winner, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_cand  = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      w_cand = 32'(r_ptr) + i;
      if (w_cand >= NUM_SRC) w_cand = w_cand - NUM_SRC;
      if (!w_found && src_valid[SRC_W'(w_cand)]) begin
        w_found = 1'b1;
        w_win   = SRC_W'(w_cand);
      end
    end
  end

  // Only the granted source sees ready, and only when the output register can take a byte.
  always_comb begin
    src_ready = '0;
    if (r_state == ST_GRANT && w_out_free) src_ready[r_grant] = 1'b1;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_nxt    = r_grant;
    w_busy_nxt     = r_busy;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_wd_nxt       = r_wd;
    w_tmo_nxt      = r_tmo;

    if (r_tx_valid && uart_tx_ready) w_tx_valid_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_ptr_nxt   = w_win;
          w_grant_nxt = w_win;
          w_busy_nxt  = 1'b1;
          w_wd_nxt    = '0;
        end
      end
      ST_GRANT: begin
        if (w_accept) begin
          w_tx_data_nxt  = w_sel_data;
          w_tx_valid_nxt = 1'b1;
          w_wd_nxt       = '0;
          if (w_sel_last) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end else if (!w_sel_valid) begin
          // Pointer stays on the stalled source so it drops to lowest priority.
          if (r_wd == WD_W'(TIMEOUT - 1)) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_wd_nxt    = '0;
            if (r_tmo != '1) w_tmo_nxt = r_tmo + CNT_W'(1);
          end else begin
            w_wd_nxt = r_wd + WD_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= SRC_W'(NUM_SRC - 1);
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_wd       <= '0;
      r_tmo      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_busy     <= w_busy_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_wd       <= w_wd_nxt;
      r_tmo      <= w_tmo_nxt;
    end
  end

  assign uart_tx_data  = r_tx_data;
  assign uart_tx_valid = r_tx_valid;
  assign grant_id      = r_grant;
  assign busy          = r_busy;
  assign timeout_count = r_tmo;

endmodule
